// File: rtl/pc_gen.sv
// Fetch-stage program counter with a ready/valid handshake, stall, exception
// redirect and a circular return-address stack for call/return.
module pc_gen #(
    parameter int unsigned      XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter logic [31:0]      EXC_VECTOR   = 32'h0000_0080,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            fetch_ready,
    input  logic [2:0]      pc_control,
    input  logic [25:0]     jump_address,
    input  logic [15:0]     branch_offset,
    input  logic [XLEN-1:0] reg_address,
    input  logic            exception,
    output logic [XLEN-1:0] pc,
    output logic            fetch_valid,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_overflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    typedef enum logic [2:0] {
        MODE_SEQ    = 3'b000,
        MODE_JUMP   = 3'b001,
        MODE_REG    = 3'b010,
        MODE_BRANCH = 3'b011,
        MODE_CALL   = 3'b100,
        MODE_RETURN = 3'b101
    } pc_mode_e;

    logic [XLEN-1:0]  pc_q, pc_d;
    logic             fetch_valid_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [XLEN-1:0]  ras_q [RAS_DEPTH];

    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  jump_target;
    logic [XLEN-1:0]  branch_target;
    logic [PTR_W-1:0] top_idx;
    logic             advance;
    logic             push;
    pc_mode_e         mode;

    assign advance       = fetch_valid_q & fetch_ready & ~stall;
    assign pc_plus4      = pc_q + XLEN'(4);
    assign jump_target   = {pc_plus4[XLEN-1:28], jump_address, 2'b00};
    assign branch_target = pc_plus4 + {{(XLEN-18){branch_offset[15]}}, branch_offset, 2'b00};
    assign top_idx       = wr_ptr_q - PTR_W'(1);
    assign mode          = pc_mode_e'(pc_control);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        pc_d       = pc_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        push       = 1'b0;

        // Exception outranks stall/handshake and leaves the RAS untouched.
        if (fetch_valid_q && exception) begin
            pc_d = XLEN'(EXC_VECTOR);
        end else if (advance) begin
            case (mode)
                MODE_JUMP:   pc_d = jump_target;
                MODE_REG:    pc_d = reg_address;
                MODE_BRANCH: pc_d = branch_target;
                MODE_CALL: begin
                    pc_d     = jump_target;
                    push     = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    if (count_q == CNT_FULL) overflow_d = 1'b1;
                    else                     count_d    = count_q + CNT_W'(1);
                end
                MODE_RETURN: begin
                    if (count_q != '0) begin
                        pc_d     = ras_q[top_idx];
                        wr_ptr_d = top_idx;
                        count_d  = count_q - CNT_W'(1);
                    end else begin
                        pc_d = reg_address;
                    end
                end
                default:     pc_d = pc_plus4;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            fetch_valid_q <= 1'b1;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
        end
    end

    // NOTE: RAS storage has no reset; count_q == 0 already marks every entry dead.
    always_ff @(posedge clk) begin
        if (push) ras_q[wr_ptr_q] <= pc_plus4;
    end

    assign pc           = pc_q;
    assign fetch_valid  = fetch_valid_q;
    assign ras_empty    = (count_q == '0);
    assign ras_full     = (count_q == CNT_FULL);
    assign ras_overflow = overflow_q;

endmodule
